// File: rtl/sr_bank_pkg.sv
// Shared constants and the round-robin pick helper for the SR cell bank arbiter.
package sr_bank_pkg;

  // {s,r} command encodings
  localparam logic [1:0] CMD_NOP = 2'b00;
  localparam logic [1:0] CMD_CLR = 2'b01;
  localparam logic [1:0] CMD_SET = 2'b10;
  localparam logic [1:0] CMD_ILL = 2'b11;

  // Widest requester vector the pick helper handles; callers zero-extend into it.
  localparam int RR_MAX = 32;
  localparam int RR_IW  = 5;

  // One-hot grant to the first valid requester at or above ptr, wrapping modulo nreq.
  function automatic logic [RR_MAX-1:0] rr_pick(input logic [RR_MAX-1:0] valid,
                                                input int unsigned       nreq,
                                                input int unsigned       ptr);
    logic [RR_MAX-1:0] grant;
    int unsigned       k;
    grant = '0;
    for (int unsigned o = 0; o < RR_MAX; o++) begin
      if (o < nreq) begin
        k = (ptr + o) % nreq;
        if (valid[k[RR_IW-1:0]] && (grant == '0)) grant[k[RR_IW-1:0]] = 1'b1;
      end
    end
    return grant;
  endfunction

endpackage

// File: rtl/sr_bank_arbiter_cell.sv
// Single SR flip-flop cell: 00 hold, 01 clear, 10 set, 11 hold (never driven by the arbiter).
module sr_cell (
  input  logic clk,
  input  logic rst_n,
  input  logic s,
  input  logic r,
  output logic q
);

  // Cell state update from the {s,r} pair.
  // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= 1'b0;
    end else begin
      case ({s, r})
        2'b01:   q <= 1'b0;
        2'b10:   q <= 1'b1;
        default: q <= q;
      endcase
    end
  end

endmodule

// File: rtl/sr_bank_arbiter.sv
// Bank of NBITS SR cells with round-robin shared write access among NREQ requesters.
// One command is accepted per cycle; the illegal {1,1} encoding and out-of-range indices
// are trapped into a sticky error flag and never reach the cells.
module sr_bank_arbiter
  import sr_bank_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int NBITS = 8,
  parameter int IDXW  = $clog2(NBITS),
  parameter int RIDW  = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr_all,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [2*NREQ-1:0]    req_cmd,
  input  logic [IDXW*NREQ-1:0] req_idx,
  output logic [NREQ-1:0]      req_ready,
  output logic [NBITS-1:0]     q,
  output logic                 err,
  output logic [RIDW-1:0]      err_rid,
  input  logic                 err_clr
);

  localparam bit IDX_POW2 = ((1 << IDXW) == NBITS);

  logic [RIDW-1:0]   rr_ptr;
  logic [RR_MAX-1:0] valid_ext;
  logic [RR_MAX-1:0] grant_ext;
  logic [NREQ-1:0]   grant;
  logic              acc;
  logic [RIDW-1:0]   win_id;
  logic [1:0]        sel_cmd;
  logic [IDXW-1:0]   sel_idx;
  logic              idx_ok;
  logic              ill;
  logic [NBITS-1:0]  cell_s;
  logic [NBITS-1:0]  cell_r;

  // Arbitration: no grant while in reset or during a bulk clear.
  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    valid_ext = '0;
    if (rst_n && !clr_all) valid_ext[NREQ-1:0] = req_valid;
    grant_ext = rr_pick(valid_ext, NREQ, 32'(rr_ptr));
    grant     = grant_ext[NREQ-1:0];
    acc       = |grant_ext;
    req_ready = grant;
  end

  // Winner mux: id, command and target index of the granted requester.
  always_comb begin
    win_id  = '0;
    sel_cmd = CMD_NOP;
    sel_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        win_id  = RIDW'(i);
        sel_cmd = req_cmd[2*i +: 2];
        sel_idx = req_idx[IDXW*i +: IDXW];
      end
    end
    idx_ok = IDX_POW2 || (32'(sel_idx) < 32'(NBITS));
    ill    = acc && ((sel_cmd == CMD_ILL) || !idx_ok);
  end

  // Cell drive decode: only the addressed cell sees the accepted command; bulk clear hits all.
  always_comb begin
    cell_s = '0;
    cell_r = '0;
    for (int b = 0; b < NBITS; b++) begin
      if (acc && idx_ok && (sel_idx == IDXW'(b))) begin
        cell_s[b] = (sel_cmd == CMD_SET);
        cell_r[b] = (sel_cmd == CMD_CLR);
      end
      if (clr_all) cell_r[b] = 1'b1;
    end
  end

  // Round-robin pointer and sticky error tracking; a new error wins over err_clr.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr  <= '0;
      err     <= 1'b0;
      err_rid <= '0;
    end else begin
      if (acc) rr_ptr <= (win_id == RIDW'(NREQ - 1)) ? '0 : win_id + 1'b1;
      if (ill) begin
        err     <= 1'b1;
        err_rid <= win_id;
      end else if (err_clr) begin
        err <= 1'b0;
      end
    end
  end

  // Cell array.
  for (genvar b = 0; b < NBITS; b++) begin : g_cell
    sr_cell u_cell (
      .clk   (clk),
      .rst_n (rst_n),
      .s     (cell_s[b]),
      .r     (cell_r[b]),
      .q     (q[b])
    );
  end

endmodule

// File: tb/tb_sr_bank_arbiter.sv
// Self-checking bench for sr_bank_arbiter: directed scenarios then randomized traffic,
// all checked against a behavioural model of the bank, error flag and rotating priority.
module tb_sr_bank_arbiter;

  localparam int NREQ  = 4;
  localparam int NBITS = 8;
  localparam int IDXW  = 3;
  localparam int RIDW  = 2;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 clr_all;
  logic                 err_clr;
  logic [NREQ-1:0]      req_valid;
  logic [2*NREQ-1:0]    req_cmd;
  logic [IDXW*NREQ-1:0] req_idx;
  logic [NREQ-1:0]      req_ready;
  logic [NBITS-1:0]     q;
  logic                 err;
  logic [RIDW-1:0]      err_rid;

  sr_bank_arbiter #(.NREQ(NREQ), .NBITS(NBITS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr_all   (clr_all),
    .req_valid (req_valid),
    .req_cmd   (req_cmd),
    .req_idx   (req_idx),
    .req_ready (req_ready),
    .q         (q),
    .err       (err),
    .err_rid   (err_rid),
    .err_clr   (err_clr)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: bank contents, error state, and the requester with top priority.
  logic [NBITS-1:0] m_q;
  bit               m_err;
  int               m_rid;
  int               m_ptr;
  int               last_w;

  function automatic int m_winner();
    if (!rst_n || clr_all) return -1;
    for (int o = 0; o < NREQ; o++) begin
      if (req_valid[(m_ptr + o) % NREQ]) return (m_ptr + o) % NREQ;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_q = '0; m_err = 0; m_rid = 0; m_ptr = 0; last_w = -1;
  endtask

  task automatic idle();
    clr_all = 0; err_clr = 0; req_valid = '0; req_cmd = '0; req_idx = '0;
  endtask

  task automatic drive(input int i, input logic [1:0] c, input int idx);
    req_valid[i]              = 1'b1;
    req_cmd[2*i +: 2]         = c;
    req_idx[IDXW*i +: IDXW]   = IDXW'(idx);
  endtask

  // One clock cycle: inputs are already driven (after a negedge).
  task automatic step();
    int          w;
    logic [1:0]  c;
    int          ix;
    bit          ill;
    #1;
    w = m_winner();
    check("ready", 32'(req_ready), (w < 0) ? 32'd0 : (32'd1 << w));
    @(posedge clk);
    ill = 0;
    if (clr_all) begin
      m_q = '0;
    end else if (w >= 0) begin
      c  = req_cmd[2*w +: 2];
      ix = int'(req_idx[IDXW*w +: IDXW]);
      if (c == 2'b01) m_q[ix] = 1'b0;
      if (c == 2'b10) m_q[ix] = 1'b1;
      if (c == 2'b11) ill = 1;
      m_ptr = (w + 1) % NREQ;
    end
    if (ill) begin
      m_err = 1; m_rid = w;
    end else if (err_clr) begin
      m_err = 0;
    end
    last_w = w;
    #1;
    check("q", 32'(q), 32'(m_q));
    check("err", 32'(err), 32'(m_err));
    check("err_rid", 32'(err_rid), 32'(m_rid));
    @(negedge clk);
  endtask

  task automatic do_reset();
    idle();
    req_valid = '1;
    rst_n = 0;
    #3;
    model_reset();
    check("rst_q", 32'(q), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    idle();
    rst_n = 1;
  endtask

  // Load the bank with an exact pattern: bulk clear, then set each bit through requester 0.
  task automatic load(input logic [NBITS-1:0] pat);
    idle(); clr_all = 1; step();
    for (int b = 0; b < NBITS; b++) begin
      if (pat[b]) begin
        idle(); drive(0, 2'b10, b); step();
      end
    end
    idle();
  endtask

  initial begin
    rst_n = 0;
    idle();
    @(negedge clk);
    do_reset();

    // 1: single set
    drive(0, 2'b10, 3);
    #1 check("t1_ready", 32'(req_ready), 32'h1);
    step();
    check("t1_q", 32'(q), 32'h08);
    check("t1_err", 32'(err), 32'd0);

    // 2: three held requesters served in rotation from pointer 0
    do_reset();
    drive(0, 2'b10, 0); drive(1, 2'b10, 1); drive(2, 2'b10, 2);
    for (int k = 0; k < 3; k++) begin
      step();
      check("t2_winner", 32'(last_w), 32'(k));
      req_valid[k] = 1'b0;
    end
    check("t2_q", 32'(q), 32'h07);
    idle(); req_valid = '1;
    #1 check("t2_ptr3", 32'(req_ready), 32'h8);
    idle();

    // 3: illegal command keeps q, sets err; err_clr alone clears it
    load(8'hFF);
    drive(2, 2'b11, 5); step();
    check("t3_q", 32'(q), 32'hFF);
    check("t3_err", 32'(err), 32'd1);
    check("t3_rid", 32'(err_rid), 32'd2);
    idle(); err_clr = 1; step();
    check("t3_clr", 32'(err), 32'd0);

    // 4: bulk clear blocks the request for one cycle
    load(8'h0F);
    clr_all = 1; drive(1, 2'b10, 7);
    #1 check("t4_ready0", 32'(req_ready), 32'd0);
    step();
    check("t4_q0", 32'(q), 32'd0);
    clr_all = 0;
    step();
    check("t4_q80", 32'(q), 32'h80);
    idle();

    // 5: new error beats err_clr
    drive(0, 2'b11, 1); step(); idle();
    drive(3, 2'b11, 2); err_clr = 1; step();
    check("t5_err", 32'(err), 32'd1);
    check("t5_rid", 32'(err_rid), 32'd3);
    idle();

    // 6: asynchronous reset mid-cycle
    load(8'hA5);
    drive(1, 2'b11, 0); step(); idle();
    check("t6_pre", 32'(q), 32'hA5);
    drive(2, 2'b10, 6);
    @(posedge clk); #2;
    rst_n = 0;
    #1;
    check("t6_q", 32'(q), 32'd0);
    check("t6_err", 32'(err), 32'd0);
    check("t6_ready", 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    check("t6_ready_hold", 32'(req_ready), 32'd0);
    check("t6_q_hold", 32'(q), 32'd0);
    @(negedge clk);
    model_reset();
    idle();
    rst_n = 1;

    // Randomized traffic; a requester left unserved keeps its command stable.
    for (int n = 0; n < 600; n++) begin
      clr_all = ($urandom_range(19) == 0);
      err_clr = ($urandom_range(7) == 0);
      for (int i = 0; i < NREQ; i++) begin
        if (!(req_valid[i] && last_w != i)) begin
          req_valid[i]            = ($urandom_range(2) != 0);
          req_cmd[2*i +: 2]       = ($urandom_range(9) == 0) ? 2'b11 : 2'($urandom_range(2));
          req_idx[IDXW*i +: IDXW] = IDXW'($urandom_range(NBITS - 1));
        end
      end
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Absolute time bound so a stuck run still reports.
  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish by 200000");
    $fatal(1, "timeout");
  end

endmodule
